jedro_1_ifu_ctrl: RTL and testbench
===================================

// Module: jedro_1_ifu_ctrl
// PURPOSE
//  Instruction-fetch controller that sequences the decoder's instruction stream. It generates
//  the PC, issues requests on the instruction-memory req/gnt/rvalid bus, and buffers responses
//  in a small in-order FIFO. It presents one instruction at a time to the decoder over a
//  valid/ready handshake. It also handles redirects (jumps/branches) from execute, including
//  discarding stale in-flight responses.
// PARAMETERS
//  DATA_WIDTH   32            instruction width
//  ADDR_WIDTH   32            PC / memory address width
//  BOOT_ADDR    32'h0000_0000 first fetch address after reset (word aligned)
//  FIFO_DEPTH   2             prefetch entries; power of 2, >=2
// PORTS
//  clk_i          in   1           clock
//  rst_i          in   1           reset; synchronous, active-high
//  jmp_en_i       in   1           redirect strobe from execute
//  jmp_addr_i     in   ADDR_WIDTH  redirect target
//  imem_req_o     out  1           fetch request
//  imem_addr_o    out  ADDR_WIDTH  fetch address
//  imem_gnt_i     in   1           request accepted (req & gnt)
//  imem_rvalid_i  in   1           response valid (in order, >=1 cycle after gnt)
//  imem_rdata_i   in   DATA_WIDTH  response data
//  instr_valid_o  out  1           instruction available to decoder
//  instr_rdata_o  out  DATA_WIDTH  instruction word (FIFO head)
//  instr_addr_o   out  ADDR_WIDTH  PC of instr_rdata_o
//  instr_ready_i  in   1           decoder accepts the head entry
// BEHAVIOUR
//  Reset: imem_req_o=0, imem_addr_o=BOOT_ADDR, instr_valid_o=0, instr_rdata_o=0,
//   instr_addr_o=0. FIFO empty, outstanding=0, discard=0, state=S_BOOT.
//  FSM:
//   S_BOOT  -> S_RUN after 1 cycle; no request is issued in S_BOOT.
//   S_RUN   issues requests; on jmp_en_i with outstanding>0 (counted after this cycle's
//           gnt/rvalid) -> S_DRAIN, else stays in S_RUN.
//   S_DRAIN no new requests; each rvalid decrements discard and its data is dropped;
//           -> S_RUN when discard reaches 0.
//  Issue rule: imem_req_o=1 in S_RUN when fifo_count+outstanding < FIFO_DEPTH.
//  Request stability: once asserted, req and addr are held until gnt, even across jmp_en_i.
//   A stale request granted after a jump is added to discard.
//  On req&gnt: outstanding+1; PC+=4, modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0).
//  On rvalid with discard=0: push {rdata, PC} into the FIFO, outstanding-1.
//   rvalid with outstanding=0 is a protocol error (bench assertion); it is ignored.
//  Decoder side: instr_valid_o = FIFO non-empty; pop on valid&ready. Head data and address
//   stay stable while valid & !ready. Push and pop in the same cycle are both honoured.
//  Latency: gnt at cycle T, rvalid at T+1 (earliest), instr_valid_o at T+2. Steady-state
//   throughput is 1 instr/cycle with gnt=1 and ready=1.
//  Redirect (jmp_en_i=1): at the next edge the FIFO is cleared, instr_valid_o=0,
//   PC<=jmp_addr_i with bits [1:0] forced to 0, discard<=outstanding. Responses arriving in
//   the same cycle as the jump count as stale. The first post-jump request goes out the
//   cycle after discard=0 (or the cycle after the jump if nothing was in flight).
//   jmp_en_i overrides a simultaneous pop.
//  Reset mid-operation: all state returns to reset values; later rvalids for pre-reset
//   requests are a system error and are out of scope.
// CONFIGURATION
//  JEDRO_1_IFU_MISALIGN_EN defined: adds output port jmp_misaligned_o (1 bit, reset 0).
//   It pulses for 1 cycle when jmp_en_i=1 and jmp_addr_i[1:0]!=0; that jump is ignored
//   (no flush, PC unchanged).
//  Undefined: no such port; jmp_addr_i[1:0] are silently forced to 0.
// TESTING
//  1. Reset release, gnt=1, rvalid 1 cycle after gnt, ready=1 -> imem_addr_o 0x0,0x4,0x8...;
//     first instr_valid_o 3 cycles after reset drop (S_BOOT+T+2); 1 instr/cycle thereafter.
//  2. ready=0 from start -> exactly 2 grants then imem_req_o=0; instr_rdata_o/addr_o held
//     at 0x0 data; raising ready resumes fetch at 0x8.
//  3. 2 requests outstanding, jmp_en_i to 0x100 -> both responses dropped, valid stays 0,
//     next imem_addr_o=0x100, first instr_addr_o=0x100.
//  4. gnt=0 for 5 cycles -> imem_req_o=1 and imem_addr_o unchanged all 5 cycles.
//  5. jmp to 0xFFFF_FFFC, gnt=1 -> request addresses 0xFFFF_FFFC then 0x0000_0000.
//  6. (JEDRO_1_IFU_MISALIGN_EN) jmp to 0x102 -> jmp_misaligned_o=1 for 1 cycle, no flush,
//     fetch continues sequentially.

Source files
------------

// File: rtl/jedro_1_ifu_ctrl.sv
// jedro_1_ifu_ctrl: instruction-fetch controller.
// Generates the PC, issues req/gnt/rvalid fetches, buffers responses in an
// in-order prefetch FIFO and hands instructions to the decoder.
// Handshakes: imem side transfers a request when imem_req_o & imem_gnt_i;
// once raised, req and addr hold until granted. Decoder side transfers the
// head entry when instr_valid_o & instr_ready_i; head is stable otherwise.
// Optional feature macro: JEDRO_1_IFU_MISALIGN_EN adds jmp_misaligned_o and
// ignores jumps to non-word-aligned targets.
module jedro_1_ifu_ctrl #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jmp_en_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_ready_i
`ifdef JEDRO_1_IFU_MISALIGN_EN
  , output logic                jmp_misaligned_o
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         disc_q, disc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic                  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic                  hold_stale_q, hold_stale_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [FIFO_DEPTH];

  logic                  jmp_eff;
  logic [ADDR_WIDTH-1:0] jmp_tgt;
  logic                  pop, rsp, push, fire, stale_fire, issue;
  logic [CW-1:0]         occ_eff;

  // Low address bits are always cleared on the redirect target.
  assign jmp_tgt = jmp_addr_i & ~ADDR_WIDTH'(3);

`ifdef JEDRO_1_IFU_MISALIGN_EN
  logic mis_q, mis_d;
  assign jmp_eff          = jmp_en_i & (jmp_addr_i[1:0] == 2'b00);
  assign mis_d            = jmp_en_i & (jmp_addr_i[1:0] != 2'b00);
  assign jmp_misaligned_o = mis_q;

  // One-cycle pulse flagging an ignored misaligned jump.
  always_ff @(posedge clk_i) begin
    if (rst_i) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`else
  assign jmp_eff = jmp_en_i;
`endif

  assign instr_valid_o = (cnt_q != '0);
  assign instr_rdata_o = fifo_data_q[rptr_q];
  assign instr_addr_o  = fifo_addr_q[rptr_q];

  // A head being popped this cycle already counts as free space, so
  // back-to-back fetch sustains one instruction per cycle.
  assign pop     = instr_valid_o & instr_ready_i & ~jmp_eff;
  assign occ_eff = cnt_q + out_q - {{(CW-1){1'b0}}, pop};
  assign issue   = (state_q == S_RUN) & (occ_eff < DEPTH_C);

  assign imem_req_o  = hold_q | issue;
  assign imem_addr_o = hold_q ? hold_addr_q : pc_q;

  assign fire       = imem_req_o & imem_gnt_i;
  assign stale_fire = fire & hold_q & hold_stale_q;
  assign rsp        = imem_rvalid_i & (out_q != '0);
  assign push       = rsp & (disc_q == '0) & ~jmp_eff;

  // Next-state computation for PC, counters, FIFO and request hold.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    disc_d       = disc_q;
    fifo_data_d  = fifo_data_q;
    fifo_addr_d  = fifo_addr_q;
    out_d        = out_q + {{(CW-1){1'b0}}, fire} - {{(CW-1){1'b0}}, rsp};
    hold_d       = imem_req_o & ~imem_gnt_i;
    hold_addr_d  = imem_addr_o;
    hold_stale_d = hold_d & ((hold_q & hold_stale_q) | jmp_eff);

    // A stale request granted after a jump must not advance the new PC.
    if (fire && !stale_fire) pc_d = pc_q + ADDR_WIDTH'(4);

    if (jmp_eff) begin
      pc_d   = jmp_tgt;
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
      disc_d = out_d;
    end else begin
      if (push) begin
        fifo_data_d[wptr_q] = imem_rdata_i;
        fifo_addr_d[wptr_q] = pc_in_flight(wptr_q);
        wptr_d              = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);
      cnt_d  = cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      disc_d = disc_q - {{(CW-1){1'b0}}, (rsp && disc_q != '0)}
                      + {{(CW-1){1'b0}}, stale_fire};
    end

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN,
      S_DRAIN: state_d = (disc_d != '0) ? S_DRAIN : S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Addresses of granted, still-useful requests, in issue order; the
  // oldest matches the next non-discarded response.
  logic [ADDR_WIDTH-1:0] pend_addr_q [FIFO_DEPTH+1];
  logic [ADDR_WIDTH-1:0] pend_addr_d [FIFO_DEPTH+1];

  function automatic logic [ADDR_WIDTH-1:0] pc_in_flight(input logic [PW-1:0] unused_idx);
    logic unused_b;
    unused_b     = ^unused_idx;
    pc_in_flight = pend_addr_q[0];
  endfunction

  // In-flight address shift queue: append on grant, shift out on response.
  always_comb begin
    pend_addr_d = pend_addr_q;
    if (rsp) begin
      for (int i = 0; i < FIFO_DEPTH; i++) pend_addr_d[i] = pend_addr_q[i+1];
      pend_addr_d[FIFO_DEPTH] = '0;
    end
    if (fire) pend_addr_d[out_d - 1'b1] = imem_addr_o;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_BOOT;
      pc_q         <= BOOT_ADDR;
      out_q        <= '0;
      disc_q       <= '0;
      cnt_q        <= '0;
      rptr_q       <= '0;
      wptr_q       <= '0;
      hold_q       <= 1'b0;
      hold_addr_q  <= '0;
      hold_stale_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
      for (int i = 0; i <= FIFO_DEPTH; i++) pend_addr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      cnt_q        <= cnt_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      hold_q       <= hold_d;
      hold_addr_q  <= hold_addr_d;
      hold_stale_q <= hold_stale_d;
      fifo_data_q  <= fifo_data_d;
      fifo_addr_q  <= fifo_addr_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_jedro_1_ifu_ctrl.sv
// tb_jedro_1_ifu_ctrl: randomized bench with a transaction-level model of
// the fetch unit (fetch pointer, discard count, expected-instruction queue).
module tb_jedro_1_ifu_ctrl;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        jmp_en = 1'b0;
  logic [31:0] jmp_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;
  logic        instr_ready = 1'b0;
`ifdef JEDRO_1_IFU_MISALIGN_EN
  logic        jmp_mis;
`endif

  jedro_1_ifu_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(32'h0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .jmp_en_i(jmp_en), .jmp_addr_i(jmp_addr),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_rdata_o(instr_rdata),
    .instr_addr_o(instr_addr), .instr_ready_i(instr_ready)
`ifdef JEDRO_1_IFU_MISALIGN_EN
    , .jmp_misaligned_o(jmp_mis)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  logic [31:0] exp_q[$];        // expected buffered instruction addresses
  logic [31:0] resp_addr_q[$];  // memory: granted addresses awaiting response
  int          resp_due_q[$];
  int          disc;
  bit          booted, held, held_stale, mis_prev;
  logic [31:0] held_addr, fp;
  int          cyc;
  int          gnt_pct, rdy_pct, lat_min, lat_max;

  bit          s_req[64], s_gnt[64], s_valid[64], s_mis[64];
  logic [31:0] s_addr[64], s_iaddr[64], s_rdata[64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; jmp_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_rdata", instr_rdata, 32'h0);
    chk("rst_iaddr", instr_addr, 32'h0);
    exp_q.delete(); resp_addr_q.delete(); resp_due_q.delete();
    disc = 0; booted = 0; held = 0; held_stale = 0; mis_prev = 0;
    held_addr = '0; fp = 32'h0; cyc = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit do_jmp, input logic [31:0] tgt);
    bit jeff, pop, g, stale_g, exp_req, n_held, n_stale, rv;
    int occ, out, load;
    logic [31:0] exp_a, r_addr, n_haddr;
    imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    instr_ready = ($urandom_range(0, 99) < rdy_pct);
    jmp_en      = do_jmp;
    jmp_addr    = tgt;
    rv          = 1'b0;
    imem_rdata  = $urandom;
    if (resp_addr_q.size() > 0 && resp_due_q[0] <= cyc) begin
      rv = 1'b1;
      imem_rdata = mem_word(resp_addr_q[0]);
    end
    imem_rvalid = rv;
    #1;
    jeff = do_jmp;
`ifdef JEDRO_1_IFU_MISALIGN_EN
    jeff = do_jmp && (tgt[1:0] == 2'b00);
    chk("misaligned", {31'b0, jmp_mis}, {31'b0, mis_prev});
    mis_prev = do_jmp && (tgt[1:0] != 2'b00);
    if (cyc < 64) s_mis[cyc] = jmp_mis;
`endif
    occ  = exp_q.size();
    out  = resp_addr_q.size();
    pop  = (occ > 0) && instr_ready && !jeff;
    load = occ - (pop ? 1 : 0) + out;
    exp_req = held || (booted && disc == 0 && load < DEPTH);
    exp_a   = held ? held_addr : fp;
    chk("req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", imem_addr, exp_a);
    chk("valid", {31'b0, instr_valid}, {31'b0, (occ > 0)});
    if (occ > 0) begin
      chk("instr_addr", instr_addr, exp_q[0]);
      chk("instr_rdata", instr_rdata, mem_word(exp_q[0]));
    end
    if (cyc < 64) begin
      s_req[cyc] = imem_req; s_gnt[cyc] = imem_gnt; s_addr[cyc] = imem_addr;
      s_valid[cyc] = instr_valid; s_iaddr[cyc] = instr_addr; s_rdata[cyc] = instr_rdata;
    end
    // memory side follows the actual bus
    g       = imem_req && imem_gnt;
    stale_g = g && held && held_stale;
    r_addr  = '0;
    if (rv) begin
      r_addr = resp_addr_q.pop_front();
      void'(resp_due_q.pop_front());
    end
    if (g) begin
      resp_addr_q.push_back(imem_addr);
      resp_due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
    end
    n_held  = exp_req && !imem_gnt;
    n_haddr = exp_a;
    n_stale = n_held && ((held && held_stale) || jeff);
    if (g && !stale_g) fp = fp + 32'd4;
    if (jeff) begin
      exp_q.delete();
      disc = resp_addr_q.size();
      fp   = tgt & ~32'd3;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (rv) begin
        if (disc > 0) disc--;
        else exp_q.push_back(r_addr);
      end
      if (stale_g) disc++;
    end
    held = n_held; held_addr = n_haddr; held_stale = n_stale;
    booted = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic knobs(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int grants;
    logic [31:0] tgt;

    // 1: sequential fetch, full throughput
    knobs(100, 100, 1, 1);
    do_reset();
    repeat (12) step(1'b0, '0);
    chk("t1_boot_noreq", {31'b0, s_req[0]}, 32'h0);
    chk("t1_req1", {31'b0, s_req[1]}, 32'h1);
    chk("t1_addr1", s_addr[1], 32'h0);
    chk("t1_addr2", s_addr[2], 32'h4);
    chk("t1_addr3", s_addr[3], 32'h8);
    chk("t1_valid2", {31'b0, s_valid[2]}, 32'h0);
    chk("t1_rdata3", s_rdata[3], 32'h1234_5678);
    for (int i = 3; i <= 10; i++) begin
      chk("t1_valid_stream", {31'b0, s_valid[i]}, 32'h1);
      chk("t1_iaddr_stream", s_iaddr[i], 32'(4 * (i - 3)));
    end

    // 2: decoder stalled from start
    knobs(100, 0, 1, 1);
    do_reset();
    repeat (10) step(1'b0, '0);
    grants = 0;
    for (int i = 0; i < 10; i++) if (s_req[i] && s_gnt[i]) grants++;
    chk("t2_grants", 32'(grants), 32'd2);
    chk("t2_req_off", {31'b0, s_req[9]}, 32'h0);
    chk("t2_head_addr", s_iaddr[9], 32'h0);
    chk("t2_head_data", s_rdata[9], 32'h1234_5678);
    rdy_pct = 100;
    step(1'b0, '0);
    chk("t2_resume_req", {31'b0, s_req[10]}, 32'h1);
    chk("t2_resume_addr", s_addr[10], 32'h8);

    // 3: jump with two requests in flight
    knobs(100, 100, 5, 5);
    do_reset();
    repeat (3) step(1'b0, '0);
    step(1'b1, 32'h100);
    repeat (17) step(1'b0, '0);
    for (int i = 3; i <= 7; i++) chk("t3_no_req", {31'b0, s_req[i]}, 32'h0);
    for (int i = 4; i <= 13; i++) chk("t3_no_valid", {31'b0, s_valid[i]}, 32'h0);
    chk("t3_req8", {31'b0, s_req[8]}, 32'h1);
    chk("t3_addr8", s_addr[8], 32'h100);
    chk("t3_valid14", {31'b0, s_valid[14]}, 32'h1);
    chk("t3_iaddr14", s_iaddr[14], 32'h100);

    // 4: grant withheld
    knobs(0, 100, 1, 1);
    do_reset();
    repeat (6) step(1'b0, '0);
    for (int i = 1; i <= 5; i++) begin
      chk("t4_req_held", {31'b0, s_req[i]}, 32'h1);
      chk("t4_addr_held", s_addr[i], 32'h0);
    end
    gnt_pct = 100;
    repeat (4) step(1'b0, '0);

    // 5: wrap-around
    knobs(100, 100, 1, 1);
    do_reset();
    step(1'b1, 32'hFFFF_FFFC);
    repeat (6) step(1'b0, '0);
    chk("t5_addr1", s_addr[1], 32'hFFFF_FFFC);
    chk("t5_addr2", s_addr[2], 32'h0);
    chk("t5_iaddr3", s_iaddr[3], 32'hFFFF_FFFC);
    chk("t5_iaddr4", s_iaddr[4], 32'h0);

`ifdef JEDRO_1_IFU_MISALIGN_EN
    // 6: misaligned jump ignored
    knobs(100, 100, 1, 1);
    do_reset();
    repeat (3) step(1'b0, '0);
    step(1'b1, 32'h102);
    repeat (6) step(1'b0, '0);
    chk("t6_mis4", {31'b0, s_mis[4]}, 32'h1);
    chk("t6_mis5", {31'b0, s_mis[5]}, 32'h0);
    for (int i = 4; i <= 8; i++) chk("t6_seq", s_iaddr[i], 32'(4 * (i - 3)));
`endif

    // random phase
    n_pops = 0;
    for (int blk = 0; blk < 20; blk++) begin
      if (blk % 5 == 0) begin
        knobs(100, 100, 1, 1);
        do_reset();
      end
      knobs($urandom_range(20, 100), $urandom_range(20, 100), 0, 0);
      lat_min = $urandom_range(1, 3);
      lat_max = lat_min + $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < 4) begin
          tgt = $urandom;
          if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
          step(1'b1, tgt);
        end else begin
          step(1'b0, '0);
        end
      end
    end
    chk("rand_progress", {31'b0, (n_pops > 100)}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
